// File: rtl/bc_pkg.sv
// Shared types and helpers for the bulls-and-cows guessing solver.
// Digit vectors are packed with index 3 as the most significant digit.
package bc_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int RES_W      = 3;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEARCH,
    S_CHECK,
    S_WAIT,
    S_DONE,
    S_FAIL
  } state_e;

  typedef struct packed {
    digits_t          digits;
    logic [RES_W-1:0] a;
    logic [RES_W-1:0] b;
  } hist_t;

  function automatic logic has_repeat(input digits_t d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = i + 1; j < NUM_DIGITS; j++)
        if (d[i] == d[j]) r = 1'b1;
    return r;
  endfunction

  // Base-10 ripple increment; the top bit is the carry out of digit 3.
  function automatic logic [NUM_DIGITS*DIGIT_W:0] inc_bcd(input digits_t d);
    digits_t n;
    logic    c;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c && d[i] == DIGIT_W'(9)) begin
        n[i] = '0;
      end else if (c) begin
        n[i] = d[i] + DIGIT_W'(1);
        c    = 1'b0;
      end else begin
        n[i] = d[i];
      end
    end
    return {c, n};
  endfunction

endpackage

// File: rtl/bc_solver_guess_score.sv
// Combinational bulls/cows scorer between two 4-digit vectors.
// A counts positional matches, B counts cross-position matches.
module guess_score
  import bc_pkg::*;
(
  input  digits_t          x_i,
  input  digits_t          y_i,
  output logic [RES_W-1:0] a_o,
  output logic [RES_W-1:0] b_o
);

  always_comb begin
    a_o = '0;
    b_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = 0; j < NUM_DIGITS; j++) begin
        if (x_i[i] == y_i[j]) begin
          if (i == j) a_o = a_o + RES_W'(1);
          else        b_o = b_o + RES_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bc_solver.sv
// Bulls-and-cows guesser: first-consistent ascending candidate search
// against the stored guess history, presenting each guess to a scorer.
module bc_solver
  import bc_pkg::*;
#(
  parameter int MAX_GUESSES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [DIGIT_W-1:0] g1,
  output logic [DIGIT_W-1:0] g2,
  output logic [DIGIT_W-1:0] g3,
  output logic [DIGIT_W-1:0] g4,
  output logic             match_en,
  input  logic [RES_W-1:0] r_a,
  input  logic [RES_W-1:0] r_b,
  input  logic             res_valid,
  output logic             busy,
  output logic             solved,
  output logic             fail,
  output logic [3:0]       guess_count
);

  localparam logic [3:0] LAST = 4'(MAX_GUESSES - 1);

  state_e     state_q;
  digits_t    cand_q;
  digits_t    g_q;
  hist_t      hist_q [MAX_GUESSES];
  logic [3:0] hist_cnt_q;
  logic [3:0] hidx_q;
  logic [3:0] gcnt_q;
  logic       match_en_q;
  logic       busy_q;
  logic       solved_q;
  logic       fail_q;

  logic [NUM_DIGITS*DIGIT_W:0] inc_w;
  digits_t          cand_d;
  logic             cand_wrap;
  hist_t            href;
  logic [RES_W-1:0] sc_a;
  logic [RES_W-1:0] sc_b;
  logic             consistent;

  assign inc_w     = inc_bcd(cand_q);
  assign cand_d    = inc_w[NUM_DIGITS*DIGIT_W-1:0];
  assign cand_wrap = inc_w[NUM_DIGITS*DIGIT_W];
  assign href      = hist_q[hidx_q];

  guess_score u_score (
    .x_i (cand_q),
    .y_i (href.digits),
    .a_o (sc_a),
    .b_o (sc_b)
  );

  assign consistent = (sc_a == href.a) && (sc_b == href.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      g_q        <= '0;
      hist_cnt_q <= '0;
      hidx_q     <= '0;
      gcnt_q     <= '0;
      match_en_q <= 1'b0;
      busy_q     <= 1'b0;
      solved_q   <= 1'b0;
      fail_q     <= 1'b0;
      for (int i = 0; i < MAX_GUESSES; i++)
        hist_q[i] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            hist_cnt_q <= '0;
            gcnt_q     <= '0;
            solved_q   <= 1'b0;
            fail_q     <= 1'b0;
            cand_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (has_repeat(cand_q)) begin
            if (cand_wrap) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FAIL;
            end else begin
              cand_q  <= cand_d;
            end
          end else if (hist_cnt_q == '0) begin
            g_q        <= cand_q;
            gcnt_q     <= gcnt_q + 4'd1;
            match_en_q <= 1'b1;
            state_q    <= S_WAIT;
          end else begin
            hidx_q  <= '0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!consistent) begin
            if (cand_wrap) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FAIL;
            end else begin
              cand_q  <= cand_d;
              state_q <= S_SEARCH;
            end
          end else if (hidx_q == hist_cnt_q - 4'd1) begin
            g_q        <= cand_q;
            gcnt_q     <= gcnt_q + 4'd1;
            match_en_q <= 1'b1;
            state_q    <= S_WAIT;
          end else begin
            hidx_q <= hidx_q + 4'd1;
          end
        end
        S_WAIT: begin
          if (res_valid) begin
            match_en_q <= 1'b0;
            if (r_a == RES_W'(4)) begin
              solved_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_DONE;
            end else if (hist_cnt_q == LAST) begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_FAIL;
            end else begin
              hist_q[hist_cnt_q] <= {cand_q, r_a, r_b};
              hist_cnt_q         <= hist_cnt_q + 4'd1;
              if (cand_wrap) begin
                fail_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_FAIL;
              end else begin
                cand_q  <= cand_d;
                state_q <= S_SEARCH;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign g1          = g_q[3];
  assign g2          = g_q[2];
  assign g3          = g_q[1];
  assign g4          = g_q[0];
  assign match_en    = match_en_q;
  assign busy        = busy_q;
  assign solved      = solved_q;
  assign fail        = fail_q;
  assign guess_count = gcnt_q;

endmodule

// File: tb/tb_bc_solver.sv
// Directed bench for bc_solver: default depth and a depth-2 instance,
// with a scripted responder scoring each presented guess.
module tb_bc_solver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       res_valid = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] r_a = '0;
  logic [2:0] r_b = '0;

  always #5 clk = ~clk;

  logic [3:0] a_g1, a_g2, a_g3, a_g4, a_gc;
  logic       a_men, a_busy, a_solved, a_fail;
  logic [3:0] b_g1, b_g2, b_g3, b_g4, b_gc;
  logic       b_men, b_busy, b_solved, b_fail;
  logic       a_start, b_start, a_rv, b_rv;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_rv    = res_valid & ~sel;
  assign b_rv    = res_valid & sel;

  bc_solver u_dut (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .g1(a_g1), .g2(a_g2), .g3(a_g3), .g4(a_g4),
    .match_en(a_men), .r_a(r_a), .r_b(r_b), .res_valid(a_rv),
    .busy(a_busy), .solved(a_solved), .fail(a_fail),
    .guess_count(a_gc)
  );

  bc_solver #(.MAX_GUESSES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .g1(b_g1), .g2(b_g2), .g3(b_g3), .g4(b_g4),
    .match_en(b_men), .r_a(r_a), .r_b(r_b), .res_valid(b_rv),
    .busy(b_busy), .solved(b_solved), .fail(b_fail),
    .guess_count(b_gc)
  );

  logic [15:0] g;
  logic [3:0]  gc;
  logic        men, busy, solved, fail;

  assign g      = sel ? {b_g1, b_g2, b_g3, b_g4} : {a_g1, a_g2, a_g3, a_g4};
  assign gc     = sel ? b_gc : a_gc;
  assign men    = sel ? b_men : a_men;
  assign busy   = sel ? b_busy : a_busy;
  assign solved = sel ? b_solved : a_solved;
  assign fail   = sel ? b_fail : a_fail;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Responder: independent bulls/cows count of guess vs secret.
  function automatic logic [5:0] score(input logic [15:0] gs,
                                       input logic [15:0] sc);
    int a, b;
    a = 0;
    b = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (gs[4*i +: 4] == sc[4*j +: 4]) begin
          if (i == j) a++;
          else        b++;
        end
    return {3'(a), 3'(b)};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_guess(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40000; n++) begin
      @(posedge clk); #1;
      if (men) begin
        ok = 1'b1;
        break;
      end
      if (!busy) break;
    end
  endtask

  task automatic respond(input string tag, input logic [2:0] a,
                         input logic [2:0] b);
    @(posedge clk); #1;
    chk({tag, "_men_wait"}, 32'(men), 1);
    r_a = a;
    r_b = b;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk({tag, "_men_off"}, 32'(men), 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 40000; n++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic play(input string tag, input logic [15:0] secret,
                      input bit zero, input int n,
                      input logic [63:0] seq);
    bit          ok;
    logic [63:0] t;
    logic [5:0]  sc;
    pulse_start();
    for (int k = 0; k < n; k++) begin
      wait_guess(ok);
      chk($sformatf("%s_found%0d", tag, k), 32'(ok), 1);
      if (!ok) return;
      t = seq >> (16 * (3 - k));
      chk($sformatf("%s_guess%0d", tag, k), 32'(g), 32'(t[15:0]));
      sc = zero ? 6'd0 : score(g, secret);
      respond(tag, sc[5:3], sc[2:0]);
    end
  endtask

  bit ok;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_g", 32'(g), 0);
    chk("rst_men", 32'(men), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({solved, fail}), 0);
    chk("rst_gc", 32'(gc), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    play("s0123", 16'h0123, 1'b0, 1, 64'h0123_0000_0000_0000);
    wait_idle("s0123");
    chk("s0123_solved", 32'(solved), 1);
    chk("s0123_gc", 32'(gc), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("s0123_hold", 32'(g), 32'h0123);

    play("s3210", 16'h3210, 1'b0, 4, 64'h0123_1032_2301_3210);
    wait_idle("s3210");
    chk("s3210_solved", 32'(solved), 1);
    chk("s3210_gc", 32'(gc), 4);
    chk("s3210_fail", 32'(fail), 0);

    play("incons", 16'h0000, 1'b1, 2, 64'h0123_4567_0000_0000);
    wait_idle("incons");
    chk("incons_fail", 32'(fail), 1);
    chk("incons_gc", 32'(gc), 2);
    chk("incons_solved", 32'(solved), 0);

    sel = 1'b1;
    play("max2", 16'h3210, 1'b0, 2, 64'h0123_1032_0000_0000);
    wait_idle("max2");
    chk("max2_fail", 32'(fail), 1);
    chk("max2_gc", 32'(gc), 2);
    chk("max2_g", 32'(g), 32'h1032);
    repeat (20) @(posedge clk);
    #1;
    chk("max2_noguess", 32'({men, gc}), 2);
    sel = 1'b0;

    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    r_a = 3'd4;
    r_b = 3'd0;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("ign_rv_busy", 32'(busy), 1);
    wait_guess(ok);
    chk("ign_found0", 32'(ok), 1);
    chk("ign_guess0", 32'(g), 32'h0123);
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    chk("ign_st_men", 32'(men), 1);
    chk("ign_st_g", 32'(g), 32'h0123);
    chk("ign_st_gc", 32'(gc), 1);
    respond("ign", 3'd0, 3'd4);
    wait_guess(ok);
    chk("ign_found1", 32'(ok), 1);
    chk("ign_guess1", 32'(g), 32'h1032);

    rst_n = 1'b0;
    #1;
    chk("arst_g", 32'(g), 0);
    chk("arst_men", 32'(men), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flags", 32'({solved, fail}), 0);
    chk("arst_gc", 32'(gc), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    wait_guess(ok);
    chk("rest_found", 32'(ok), 1);
    chk("rest_guess", 32'(g), 32'h0123);
    chk("rest_gc", 32'(gc), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
